// File: rtl/icompress_sched.sv
// icompress_sched: row scheduler around an external column compressor.
// Accepts one signed input row, strobes the compressor for one cycle, captures
// its (value, column) pairs and count, then streams the pairs downstream with
// a valid/ready handshake, tagging each beat with a wrapping row index.
// Optional feature macro: ICOMPRESS_SKIP_EMPTY_EN. When it is defined, rows
// with no non-zero pairs produce no beat. Otherwise such a row emits one
// empty-row marker beat.
module icompress_sched #(
    parameter int W_OUT         = 128,
    parameter int SIZE_in_DATA  = 14,
    parameter int SIZE_val_DATA = 8,
    parameter int SIZE_count    = 8,
    parameter int ROW_W         = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [W_OUT-1:0][SIZE_in_DATA-1:0]     in_data,
    output logic [W_OUT-1:0][SIZE_in_DATA-1:0]     comp_data,
    output logic                                   comp_enable,
    input  logic [W_OUT-1:0][SIZE_val_DATA-1:0]    comp_val,
    input  logic [W_OUT-1:0][SIZE_count-1:0]       comp_col,
    input  logic [SIZE_count-1:0]                  comp_count,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [SIZE_val_DATA-1:0]               out_val,
    output logic [SIZE_count-1:0]                  out_col,
    output logic [ROW_W-1:0]                       out_row,
    output logic                                   out_last,
    output logic                                   out_empty,
    output logic                                   busy
);

    localparam int IDX_W = (W_OUT > 1) ? $clog2(W_OUT) : 1;
    localparam logic [SIZE_count-1:0] CNT_MAX = SIZE_count'(W_OUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPRESS = 2'd1,
        STREAM   = 2'd2
    } state_e;

    state_e                                state_q, state_d;
    logic [W_OUT-1:0][SIZE_in_DATA-1:0]    comp_data_q;
    logic [W_OUT-1:0][SIZE_val_DATA-1:0]   val_buf_q;
    logic [W_OUT-1:0][SIZE_count-1:0]      col_buf_q;
    logic [SIZE_count-1:0]                 cnt_q;
    logic [SIZE_count-1:0]                 ptr_q;
    logic [ROW_W-1:0]                      row_q;
    logic [SIZE_val_DATA-1:0]              val_hold_q;
    logic [SIZE_count-1:0]                 col_hold_q;
    logic [ROW_W-1:0]                      row_hold_q;

    logic [SIZE_count-1:0]                 cnt_clamped;
    logic                                  row_empty;
    logic [SIZE_val_DATA-1:0]              cur_val;
    logic [SIZE_count-1:0]                 cur_col;
    logic                                  cur_last;

    // A compressor count beyond the row width is treated as a full row.
    assign cnt_clamped = (comp_count > CNT_MAX) ? CNT_MAX : comp_count;

`ifdef ICOMPRESS_SKIP_EMPTY_EN
    assign row_empty = 1'b0;
`else
    logic empty_q;

    // Remember whether the captured row had no pairs (marker beat pending).
    always_ff @(posedge clk) begin
        if (rst) begin
            empty_q <= 1'b0;
        end else if (state_q == COMPRESS) begin
            empty_q <= (cnt_clamped == '0);
        end
    end

    assign row_empty = empty_q;
`endif

    // Current beat contents selected from the capture buffers.
    always_comb begin
        cur_val  = row_empty ? '0 : val_buf_q[ptr_q[IDX_W-1:0]];
        cur_col  = row_empty ? '0 : col_buf_q[ptr_q[IDX_W-1:0]];
        cur_last = row_empty | (ptr_q == (cnt_q - SIZE_count'(1)));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake/strobe outputs.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        comp_enable = 1'b0;
        out_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = COMPRESS;
                end
            end
            COMPRESS: begin
                comp_enable = 1'b1;
`ifdef ICOMPRESS_SKIP_EMPTY_EN
                state_d = (cnt_clamped == '0) ? IDLE : STREAM;
`else
                state_d = STREAM;
`endif
            end
            STREAM: begin
                out_valid = 1'b1;
                if (out_ready && cur_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: row register, capture buffers, beat pointer and row index.
    always_ff @(posedge clk) begin
        if (rst) begin
            comp_data_q <= '0;
            val_buf_q   <= '0;
            col_buf_q   <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            row_q       <= '0;
            val_hold_q  <= '0;
            col_hold_q  <= '0;
            row_hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        comp_data_q <= in_data;
                    end
                end
                COMPRESS: begin
                    val_buf_q <= comp_val;
                    col_buf_q <= comp_col;
                    cnt_q     <= cnt_clamped;
                    ptr_q     <= '0;
`ifdef ICOMPRESS_SKIP_EMPTY_EN
                    if (cnt_clamped == '0) begin
                        row_q <= row_q + ROW_W'(1);
                    end
`endif
                end
                STREAM: begin
                    // Track what is shown so the bus holds it once streaming ends.
                    val_hold_q <= cur_val;
                    col_hold_q <= cur_col;
                    row_hold_q <= row_q;
                    if (out_ready) begin
                        ptr_q <= ptr_q + SIZE_count'(1);
                        if (cur_last) begin
                            row_q <= row_q + ROW_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign comp_data = comp_data_q;
    assign busy      = (state_q != IDLE);
    assign out_last  = (state_q == STREAM) & cur_last;
    assign out_empty = (state_q == STREAM) & row_empty;
    assign out_val   = (state_q == STREAM) ? cur_val : val_hold_q;
    assign out_col   = (state_q == STREAM) ? cur_col : col_hold_q;
    assign out_row   = (state_q == STREAM) ? row_q   : row_hold_q;

endmodule

// File: tb/tb_icompress_sched.sv
// tb_icompress_sched: self-checking bench for icompress_sched.
// The compressor is modelled as a stub that keeps elements whose value/256 is
// non-zero. Expected beats come from a queue-based reference model.
module tb_icompress_sched;

    localparam int W_OUT = 128;
    localparam int DW    = 14;
    localparam int VW    = 8;
    localparam int CW    = 8;
    localparam int RW    = 10;

    typedef logic [W_OUT-1:0][DW-1:0] row_t;

    typedef struct packed {
        logic [VW-1:0] val;
        logic [CW-1:0] col;
        logic          last;
        logic          empty;
    } beat_t;

    typedef struct {
        int unsigned ca;
        int unsigned da;
        int unsigned cb;
        int unsigned db;
        int unsigned n;
        int unsigned v0;
        int unsigned c0;
        int unsigned vl;
        int unsigned cl;
    } tv_t;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         in_valid;
    logic                         in_ready;
    row_t                         in_data;
    row_t                         comp_data;
    logic                         comp_enable;
    logic [W_OUT-1:0][VW-1:0]     comp_val;
    logic [W_OUT-1:0][CW-1:0]     comp_col;
    logic [CW-1:0]                comp_count;
    logic                         out_valid;
    logic                         out_ready;
    logic [VW-1:0]                out_val;
    logic [CW-1:0]                out_col;
    logic [RW-1:0]                out_row;
    logic                         out_last;
    logic                         out_empty;
    logic                         busy;

    logic                         cnt_ovr_en;
    logic [CW-1:0]                cnt_ovr;
    logic [CW-1:0]                stub_cnt;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned model_row   = 0;
    beat_t       exp_q[$];

    always #5 clk = ~clk;

    icompress_sched #(
        .W_OUT        (W_OUT),
        .SIZE_in_DATA (DW),
        .SIZE_val_DATA(VW),
        .SIZE_count   (CW),
        .ROW_W        (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .comp_data  (comp_data),
        .comp_enable(comp_enable),
        .comp_val   (comp_val),
        .comp_col   (comp_col),
        .comp_count (comp_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_val    (out_val),
        .out_col    (out_col),
        .out_row    (out_row),
        .out_last   (out_last),
        .out_empty  (out_empty),
        .busy       (busy)
    );

    // Compressor stub: pack the non-zero (element >> 8) values in column order.
    always_comb begin
        int unsigned n;
        logic [DW-1:0] q;
        n        = 0;
        q        = '0;
        comp_val = '0;
        comp_col = '0;
        for (int i = 0; i < W_OUT; i++) begin
            q = comp_data[i] >> 8;
            if (q != '0) begin
                comp_val[n] = q[VW-1:0];
                comp_col[n] = CW'(i);
                n++;
            end
        end
        stub_cnt = CW'(n);
    end

    assign comp_count = cnt_ovr_en ? cnt_ovr : stub_cnt;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_row(input string name, input row_t act, input row_t exp);
        int bad;
        bad = -1;
        vectors++;
        for (int i = W_OUT - 1; i >= 0; i--) begin
            if (act[i] !== exp[i]) bad = i;
        end
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: element %0d got 0x%0h, expected 0x%0h", name, bad, act[bad], exp[bad]);
        end
    endtask

    task automatic check_beat(input string name, input beat_t e);
        check(name, {out_valid, out_val, out_col, out_row, out_last, out_empty},
              {1'b1, e.val, e.col, RW'(model_row), e.last, e.empty});
    endtask

    // Reference model: the expected beat list of a row, from the value/256 rule.
    function automatic void build_expect(input row_t r);
        beat_t b;
        int unsigned v;
        exp_q.delete();
        for (int i = 0; i < W_OUT; i++) begin
            v = int'(r[i]) / 256;
            if (v != 0) begin
                b.val   = VW'(v);
                b.col   = CW'(i);
                b.last  = 1'b0;
                b.empty = 1'b0;
                exp_q.push_back(b);
            end
        end
        if (exp_q.size() == 0) begin
`ifndef ICOMPRESS_SKIP_EMPTY_EN
            b.val   = '0;
            b.col   = '0;
            b.last  = 1'b1;
            b.empty = 1'b1;
            exp_q.push_back(b);
`endif
        end else begin
            exp_q[exp_q.size() - 1].last = 1'b1;
        end
    endfunction

    // Offer one row, then drain and check every beat against the model.
    task automatic run_row(input row_t r, input int unsigned pct, input int stall_beat,
                           input int unsigned stall_len, output int unsigned nb,
                           output logic [15:0] first_vc, output logic [15:0] last_vc);
        int unsigned t;
        int unsigned stalls;
        beat_t e;
        nb       = 0;
        first_vc = '0;
        last_vc  = '0;
        e        = '0;
        t        = 0;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        in_data  = r;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = ~r;
        check("compress_cycle", {comp_enable, busy, in_ready, out_valid}, 4'b1100);
        check_row("comp_data", comp_data, r);
        build_expect(r);
        step();
        if (exp_q.size() == 0) begin
            check("skip_to_idle", {in_ready, out_valid, busy}, 3'b100);
            model_row = (model_row + 1) % (1 << RW);
            return;
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            e      = exp_q[k];
            stalls = ($urandom_range(0, 99) < pct) ? $urandom_range(1, 3) : 0;
            if (k == stall_beat) stalls = stall_len;
            out_ready = 1'b0;
            for (int s = 0; s < int'(stalls); s++) begin
                check_beat("stalled_beat", e);
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                step();
            end
            out_ready = 1'b1;
            check_beat("beat", e);
            check("beat_in_ready", {63'd0, in_ready}, 64'd0);
            if (nb == 0) first_vc = {out_val, out_col};
            last_vc = {out_val, out_col};
            nb++;
            step();
            out_ready = 1'b0;
        end
        check("after_row", {out_valid, out_last, out_empty, in_ready}, 4'b0001);
        check("hold_outputs", {out_val, out_col, out_row}, {e.val, e.col, RW'(model_row)});
        model_row = (model_row + 1) % (1 << RW);
    endtask

    row_t          r;
    tv_t           tv[6];
    int unsigned   nb;
    logic [15:0]   fvc;
    logic [15:0]   lvc;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_data    = '0;
        cnt_ovr_en = 1'b0;
        cnt_ovr    = '0;

        tv[0] = '{3,   512, 70,  256,  2, 2,  3,  1,  70};
        tv[1] = '{0,   300, 127, 8191, 2, 1,  0,  31, 127};
        tv[2] = '{5,   255, 9,   256,  1, 1,  9,  1,  9};
        tv[3] = '{64,  4096, 64, 4096, 1, 16, 64, 16, 64};
        tv[4] = '{10,  1000, 11, 1500, 2, 3,  10, 5,  11};
        tv[5] = '{127, 256, 0,   0,    1, 1,  127, 1, 127};

        // Reset state.
        step();
        step();
        check("reset_state", {in_ready, out_valid, out_last, out_empty, comp_enable, busy}, 6'b100000);
        check_row("reset_comp_data", comp_data, '0);
        rst = 1'b0;

        // Table-driven rows with free-flowing downstream.
        for (int i = 0; i < 6; i++) begin
            r = '0;
            r[tv[i].ca] = DW'(tv[i].da);
            if (tv[i].db != 0) r[tv[i].cb] = DW'(tv[i].db);
            run_row(r, 0, -1, 0, nb, fvc, lvc);
            check("tv_beats", 64'(nb), 64'(tv[i].n));
            check("tv_first", fvc, {VW'(tv[i].v0), CW'(tv[i].c0)});
            check("tv_last", lvc, {VW'(tv[i].vl), CW'(tv[i].cl)});
        end

        // Backpressure held for three cycles on each beat in turn.
        r = '0;
        r[3]  = DW'(512);
        r[70] = DW'(256);
        run_row(r, 0, 0, 3, nb, fvc, lvc);
        check("bp0_beats", 64'(nb), 64'd2);
        run_row(r, 0, 1, 3, nb, fvc, lvc);
        check("bp1_beats", 64'(nb), 64'd2);

        // All-zero row, then a normal row to confirm the row index advanced.
        r = '0;
        run_row(r, 0, -1, 0, nb, fvc, lvc);
`ifdef ICOMPRESS_SKIP_EMPTY_EN
        check("empty_beats", 64'(nb), 64'd0);
`else
        check("empty_beats", 64'(nb), 64'd1);
        check("empty_vc", fvc, 16'd0);
`endif
        r = '0;
        r[17] = DW'(2048);
        run_row(r, 0, -1, 0, nb, fvc, lvc);
        check("post_empty_vc", lvc, {8'd8, 8'd17});

        // Full row: every column present.
        for (int i = 0; i < W_OUT; i++) r[i] = DW'(8191);
        run_row(r, 0, -1, 0, nb, fvc, lvc);
        check("full_beats", 64'(nb), 64'd128);
        check("full_first", fvc, {8'd31, 8'd0});
        check("full_last", lvc, {8'd31, 8'd127});

        // Over-range compressor count is clamped to the row width.
        cnt_ovr_en = 1'b1;
        cnt_ovr    = 8'd200;
        run_row(r, 20, -1, 0, nb, fvc, lvc);
        check("clamp_beats", 64'(nb), 64'd128);
        cnt_ovr_en = 1'b0;

        // Random sparse rows with random backpressure.
        for (int n = 0; n < 30; n++) begin
            r = '0;
            if ($urandom_range(0, 5) != 0) begin
                for (int i = 0; i < W_OUT; i++) begin
                    if ($urandom_range(0, 99) < 5) r[i] = DW'($urandom_range(0, 8191));
                end
            end
            run_row(r, 40, -1, 0, nb, fvc, lvc);
        end

        // Reset during beat 1 of a five-beat row, with out_ready high.
        r = '0;
        for (int i = 0; i < 5; i++) r[i] = DW'(512);
        in_data  = r;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        check("rst_beat0", {out_valid, out_col}, {1'b1, 8'd0});
        step();
        check("rst_beat1", {out_valid, out_col, out_last}, {1'b1, 8'd1, 1'b0});
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        check("rst_mid_stream", {out_valid, in_ready, busy, comp_enable, out_last, out_empty}, 6'b010000);
        check_row("rst_comp_data", comp_data, '0);
        model_row = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_beats", {63'd0, out_valid}, 64'd0);
        end

        // Reset wins over an offered row in the same cycle.
        in_data  = r;
        in_valid = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_over_accept", {comp_enable, in_ready, busy}, 3'b010);
        step();
        check("rst_over_accept2", {out_valid, comp_enable}, 2'b00);

        // Row index wrap: 2^RW + 1 single-pair rows starting from row 0.
        for (int n = 0; n < (1 << RW) + 1; n++) begin
            r = '0;
            r[$urandom_range(0, W_OUT - 1)] = DW'($urandom_range(256, 8191));
            run_row(r, 0, -1, 0, nb, fvc, lvc);
        end
        check("wrap_row", 64'(out_row), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
